// File: rtl/pool_relu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_relu_if : DRAM read/write port bundle for the pool/ReLU stage    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface pool_relu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                  dram_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  dram_en_rd;
  logic                  dram_en_wr;

  modport master (
    input  dram_valid, data_in,
    output data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );

  modport slave (
    output dram_valid, data_in,
    input  data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );
endinterface
`default_nettype wire

// File: rtl/pool_relu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_relu : ReLU fused with 2x2/stride-2 max pooling over a DRAM map  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module pool_relu #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 18,
  parameter int                    MAP_WIDTH  = 24,
  parameter int                    MAP_HEIGHT = 24,
  parameter int                    NUM_CHNL   = 6,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = '0,
  parameter logic [ADDR_WIDTH-1:0] DST_BASE   = ADDR_WIDTH'(32'h10000)
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  output logic        done,
  pool_relu_if.master bus
);

  localparam int PH = MAP_HEIGHT / 2;
  localparam int PW = MAP_WIDTH / 2;
  localparam int CW = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1;
  localparam int RW = (PH > 1) ? $clog2(PH) : 1;
  localparam int QW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         c_q, c_d;
  logic [RW-1:0]         r_q, r_d;
  logic [QW-1:0]         q_q, q_d;
  logic [1:0]            k_q, k_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] addr_in_q, addr_out_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_stb, wr_stb, fin;
  logic                  last_q, last_r, last_c;

  // Window k selects the pixel at row offset k[1], column offset k[0].
  function automatic logic [ADDR_WIDTH-1:0] f_rd_addr(
    input logic [CW-1:0] c, input logic [RW-1:0] r,
    input logic [QW-1:0] q, input logic [1:0] k);
    logic [31:0] y, x, sum;
    y   = 32'(r) * 32'd2 + 32'(k[1]);
    x   = 32'(q) * 32'd2 + 32'(k[0]);
    sum = 32'(SRC_BASE) + 32'(c) * 32'(MAP_HEIGHT * MAP_WIDTH)
        + y * 32'(MAP_WIDTH) + x;
    return ADDR_WIDTH'(sum);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_wr_addr(
    input logic [CW-1:0] c, input logic [RW-1:0] r, input logic [QW-1:0] q);
    logic [31:0] sum;
    sum = 32'(DST_BASE) + 32'(c) * 32'(PH * PW) + 32'(r) * 32'(PW) + 32'(q);
    return ADDR_WIDTH'(sum);
  endfunction

  assign last_q = (q_q == QW'(PW - 1));
  assign last_r = (r_q == RW'(PH - 1));
  assign last_c = (c_q == CW'(NUM_CHNL - 1));

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      q_q     <= q_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    q_d     = q_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RD_REQ;
          c_d     = '0;
          r_d     = '0;
          q_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_RD_REQ: state_d = enable ? S_RD_WAIT : S_IDLE;
      S_RD_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (bus.dram_valid) begin
          // acc starts at zero per window, so negative pixels never win (ReLU).
          if ($signed(bus.data_in) > $signed(acc_q)) acc_d = bus.data_in;
          if (k_q == 2'd3) begin
            state_d = S_WR;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR: begin
        k_d   = '0;
        acc_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (last_q && last_r && last_c) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD_REQ;
          if (!last_q) begin
            q_d = q_q + QW'(1);
          end else begin
            q_d = '0;
            if (!last_r) begin
              r_d = r_q + RW'(1);
            end else begin
              r_d = '0;
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      S_DONE:  if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_stb = (state_q == S_RD_REQ);
    wr_stb = (state_q == S_WR);
    fin    = (state_q == S_DONE);
  end

  // Addresses/data are loaded on entry to the strobing state and held after.
  always_ff @(posedge clk) begin
    if (srst) begin
      addr_in_q  <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
    end else begin
      if (state_d == S_RD_REQ) addr_in_q <= f_rd_addr(c_d, r_d, q_d, k_d);
      if (state_d == S_WR) begin
        addr_out_q <= f_wr_addr(c_q, r_q, q_q);
        data_out_q <= acc_d;
      end
    end
  end

  assign bus.dram_en_rd = rd_stb;
  assign bus.dram_en_wr = wr_stb;
  assign bus.addr_in    = addr_in_q;
  assign bus.addr_out   = addr_out_q;
  assign bus.data_out   = data_out_q;
  assign done           = fin;

endmodule
`default_nettype wire

// File: tb/tb_pool_relu.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pool_relu : randomized bench with a window-level reference model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_pool_relu;

  localparam logic [17:0] DST  = 18'h10000;
  localparam int          SRCB = 'h40;

  logic clk = 1'b0;
  logic srst, en_a, en_b, sel;
  logic done_a, done_b;
  logic dram_valid;
  logic [31:0] data_in;

  always #5 clk = ~clk;

  pool_relu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) if_a ();
  pool_relu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(18)) if_b ();

  assign if_a.dram_valid = dram_valid;
  assign if_a.data_in    = data_in;
  assign if_b.dram_valid = dram_valid;
  assign if_b.data_in    = data_in;

  pool_relu #(.MAP_WIDTH(4), .MAP_HEIGHT(4), .NUM_CHNL(1)) u_dut_a (
    .clk(clk), .srst(srst), .enable(en_a), .done(done_a), .bus(if_a));

  pool_relu #(.MAP_WIDTH(5), .MAP_HEIGHT(5), .NUM_CHNL(2),
              .SRC_BASE(18'(SRCB))) u_dut_b (
    .clk(clk), .srst(srst), .enable(en_b), .done(done_b), .bus(if_b));

  logic        m_en_rd, m_en_wr;
  logic [17:0] m_addr_in, m_addr_out;
  logic [31:0] m_data_out;
  assign m_en_rd    = sel ? if_b.dram_en_rd : if_a.dram_en_rd;
  assign m_en_wr    = sel ? if_b.dram_en_wr : if_a.dram_en_wr;
  assign m_addr_in  = sel ? if_b.addr_in    : if_a.addr_in;
  assign m_addr_out = sel ? if_b.addr_out   : if_a.addr_out;
  assign m_data_out = sel ? if_b.data_out   : if_a.data_out;

  logic [31:0] mem [0:255];
  int          rd_q[$], wa_q[$];
  logic [31:0] wd_q[$];
  int          exp_ra[$], exp_wa[$];
  logic [31:0] exp_wd[$];

  int n_checks = 0;
  int n_errors = 0;
  bit spur = 1'b0, lat_rand = 1'b0;
  int lat_fix = 1;
  int ovl_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRAM responder and strobe monitor, all sampled on the falling edge.
  initial begin
    bit         pending = 1'b0;
    int         cnt = 0;
    logic [7:0] p_addr = '0;
    dram_valid = 1'b0;
    data_in    = '0;
    forever begin
      @(negedge clk);
      dram_valid = 1'b0;
      data_in    = $urandom;
      if (pending) begin
        if (cnt <= 1) begin
          dram_valid = 1'b1;
          data_in    = mem[p_addr];
          pending    = 1'b0;
        end else begin
          cnt--;
        end
      end else if (spur && $urandom_range(0, 2) == 0) begin
        dram_valid = 1'b1;
      end
      if (m_en_wr) begin
        wa_q.push_back(int'(m_addr_out));
        wd_q.push_back(m_data_out);
      end
      if (m_en_rd) begin
        if (pending) ovl_err++;
        rd_q.push_back(int'(m_addr_in));
        pending = 1'b1;
        p_addr  = m_addr_in[7:0];
        cnt     = lat_rand ? int'($urandom_range(1, 6)) : lat_fix;
      end
    end
  end

  // Reference: every 2x2 window is the max of zero and its four pixels.
  task automatic build_exp(input int w, input int h, input int nc, input int src);
    int ph, pw, a, y, x;
    logic signed [31:0] best, v;
    ph = h / 2;
    pw = w / 2;
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
    for (int c = 0; c < nc; c++)
      for (int r = 0; r < ph; r++)
        for (int q = 0; q < pw; q++) begin
          best = 0;
          for (int k = 0; k < 4; k++) begin
            y = 2 * r + k / 2;
            x = 2 * q + k % 2;
            a = src + c * h * w + y * w + x;
            exp_ra.push_back(a);
            v = $signed(mem[a]);
            if (v > best) best = v;
          end
          exp_wa.push_back(int'(DST) + c * ph * pw + r * pw + q);
          exp_wd.push_back(best);
        end
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_nrd"}, rd_q.size(), exp_ra.size());
    check({tag, "_nwr"}, wa_q.size(), exp_wa.size());
    for (int i = 0; i < rd_q.size() && i < exp_ra.size(); i++)
      check($sformatf("%s_ra%0d", tag, i), rd_q[i], exp_ra[i]);
    for (int i = 0; i < wa_q.size() && i < exp_wa.size(); i++) begin
      check($sformatf("%s_wa%0d", tag, i), wa_q[i], exp_wa[i]);
      check($sformatf("%s_wd%0d", tag, i), wd_q[i], exp_wd[i]);
    end
  endtask

  task automatic run(input bit use_b, input string tag, output int cycles);
    bit fin = 1'b0;
    @(negedge clk);
    sel = use_b;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    if (use_b) en_b = 1'b1; else en_a = 1'b1;
    cycles = 0;
    while (cycles < 3000 && !fin) begin
      @(negedge clk);
      cycles++;
      fin = use_b ? done_b : done_a;
    end
    check({tag, "_done_reached"}, fin, 1'b1);
    repeat (2) @(negedge clk);
    check({tag, "_done_held"}, use_b ? done_b : done_a, 1'b1);
    en_a = 1'b0;
    en_b = 1'b0;
    @(negedge clk);
    check({tag, "_done_cleared"}, use_b ? done_b : done_a, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) mem[i] = $urandom;
  endtask

  initial begin
    int       cyc, n, nr, nw;
    logic [63:0] ors;
    srst = 1'b1; en_a = 1'b0; en_b = 1'b0; sel = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    srst = 1'b0;
    ors = '0;
    n   = 0;
    repeat (10) begin
      @(negedge clk);
      ors = ors | {if_a.data_out, if_a.addr_in[13:0], if_a.addr_out[13:0],
                   if_a.dram_en_rd, if_a.dram_en_wr, done_a, 1'b0};
      n += int'(if_a.dram_en_rd) + int'(if_a.dram_en_wr) + int'(if_b.dram_en_rd)
         + int'(if_b.dram_en_wr) + int'(done_b);
    end
    check("rst_data_out", if_a.data_out, 32'h0);
    check("rst_addr_in", if_a.addr_in, 18'h0);
    check("rst_addr_out", if_a.addr_out, 18'h0);
    check("rst_b_addr_out", if_b.addr_out, 18'h0);
    check("idle_a_or", ors, 64'h0);
    check("idle_strobes", n, 0);

    // Basic pooling, ramp 0..15, L=1
    for (int i = 0; i < 16; i++) mem[i] = 32'(i) << 16;
    build_exp(4, 4, 1, 0);
    run(1'b0, "basic", cyc);
    check("basic_done_cycle", cyc, 37);
    compare_run("basic");
    if (wd_q.size() == 4) begin
      check("basic_w0", wd_q[0], 32'h0005_0000);
      check("basic_w3", wd_q[3], 32'h000F_0000);
    end

    // ReLU windows
    fill_random(0, 15);
    mem[0] = 32'hFFFF_0000; mem[1] = 32'hFFFE_0000;
    mem[4] = 32'hFFFF_8000; mem[5] = 32'hFFFD_0000;
    mem[2] = 32'hFFFB_0000; mem[3] = 32'h0000_4000;
    mem[6] = 32'hFFFB_0000; mem[7] = 32'h8000_0000;
    build_exp(4, 4, 1, 0);
    run(1'b0, "relu", cyc);
    compare_run("relu");
    if (wd_q.size() == 4) begin
      check("relu_all_neg", wd_q[0], 32'h0);
      check("relu_mixed", wd_q[1], 32'h0000_4000);
    end

    // Variable latency with spurious dram_valid
    fill_random(0, 15);
    build_exp(4, 4, 1, 0);
    spur = 1'b1; lat_rand = 1'b1;
    run(1'b0, "varlat", cyc);
    compare_run("varlat");

    // Multi-channel odd-size map
    fill_random(SRCB, SRCB + 49);
    build_exp(5, 5, 2, SRCB);
    run(1'b1, "odd", cyc);
    compare_run("odd");
    if (rd_q.size() > 16) check("odd_ch1_first_rd", rd_q[16], SRCB + 25);
    if (wa_q.size() > 4) check("odd_ch1_first_wa", wa_q[4], int'(DST) + 4);
    spur = 1'b0; lat_rand = 1'b0;

    // srst mid-run wins over enable
    fill_random(0, 15);
    @(negedge clk);
    sel = 1'b0;
    en_a = 1'b1;
    repeat (12) @(negedge clk);
    srst = 1'b1; en_a = 1'b0;
    @(negedge clk);
    check("srst_mid_en_rd", if_a.dram_en_rd, 1'b0);
    check("srst_mid_addr_out", if_a.addr_out, 18'h0);
    check("srst_mid_data_out", if_a.data_out, 32'h0);
    srst = 1'b0;
    repeat (10) @(negedge clk);

    // Abort during RD_WAIT of the third output, then restart
    fill_random(0, 15);
    build_exp(4, 4, 1, 0);
    lat_fix = 3;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    en_a = 1'b1;
    n = 0;
    while (wa_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
    while (!if_a.dram_en_rd && n < 500) begin @(negedge clk); n++; end
    check("abort_reached", n < 500, 1'b1);
    @(negedge clk);
    en_a = 1'b0;
    nr = rd_q.size();
    nw = wa_q.size();
    repeat (20) @(negedge clk);
    check("abort_no_rd", rd_q.size(), nr);
    check("abort_no_wr", wa_q.size(), nw);
    check("abort_nwr", nw, 2);
    check("abort_done_low", done_a, 1'b0);
    lat_fix = 1;
    run(1'b0, "restart", cyc);
    check("restart_done_cycle", cyc, 37);
    compare_run("restart");

    check("one_outstanding", ovl_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
